// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one W-bit ALU between two valid/ready requesters.
// Each operation is captured in IDLE, evaluated in EXEC and held in RESP until taken.
module alu_share_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         rsp1_err,
  output logic         busy
);

  localparam int SH_W = $clog2(W);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state, state_nxt;
  logic         last_served;
  logic         id;
  logic         any_valid;
  logic         grant;
  logic         accept;
  logic         rsp_fire;
  logic [3:0]   op_p0;
  logic [W-1:0] a_p0, b_p0;
  logic [W:0]   res;
  logic [W-1:0] data0_p1, data1_p1;
  logic         err0_p1, err1_p1;

  // Result packs {err, data}; illegal opcodes yield data 0 with err set.
  function automatic logic [W:0] alu_eval(input logic [3:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0] r;
    r = '0;
    case (op)
      4'd0:    r[W-1:0] = a & b;
      4'd1:    r[W-1:0] = a | b;
      4'd2:    r[W-1:0] = a ^ b;
      4'd3:    r[W-1:0] = ~a;
      4'd4:    r[W-1:0] = {a[W/2-1:0], b[W/2-1:0]};
      4'd5:    r[W-1:0] = a >> b[SH_W-1:0];
      4'd6:    r[W-1:0] = {{(W-1){1'b0}}, &b};
      4'd7:    r[W-1:0] = (a > b) ? a : b;
      4'd8:    r[W-1:0] = a - b;
      4'd9:    r[W-1:0] = a + b;
      4'd10:   r[W-1:0] = (a < b) ? a : b;
      default: r[W]     = 1'b1;
    endcase
    return r;
  endfunction

  // A tie goes to whichever requester was not served last.
  assign any_valid  = req0_valid | req1_valid;
  assign grant      = (req0_valid && req1_valid) ? ~last_served : req1_valid;
  assign req0_ready = (state == IDLE) && any_valid && !grant;
  assign req1_ready = (state == IDLE) && any_valid && grant;
  assign accept     = (state == IDLE) && any_valid;
  assign rsp_fire   = (state == RESP) && (id ? rsp1_ready : rsp0_ready);
  assign res        = alu_eval(op_p0, a_p0, b_p0);

  assign rsp0_valid = (state == RESP) && !id;
  assign rsp1_valid = (state == RESP) && id;
  assign rsp0_data  = data0_p1;
  assign rsp1_data  = data1_p1;
  assign rsp0_err   = err0_p1;
  assign rsp1_err   = err1_p1;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = EXEC;
      EXEC:                  state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      id          <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_served <= grant;
        id          <= grant;
      end
    end
  end

  // Stage p0: operand capture at acceptance; later operand changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= grant ? req1_op : req0_op;
      a_p0  <= grant ? req1_a  : req0_a;
      b_p0  <= grant ? req1_b  : req0_b;
    end
  end

  // Stage p1: result registered per port during EXEC and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_p1 <= '0;
      data1_p1 <= '0;
      err0_p1  <= 1'b0;
      err1_p1  <= 1'b0;
    end else if (state == EXEC) begin
      if (id) begin
        data1_p1 <= res[W-1:0];
        err1_p1  <= res[W];
      end else begin
        data0_p1 <= res[W-1:0];
        err0_p1  <= res[W];
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter with an arithmetic reference model.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready, rsp1_ready;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_err, rsp1_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_err(rsp1_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference: {err, data} from plain integer arithmetic.
  function automatic logic [8:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int ia, ib, r;
    ia = a;
    ib = b;
    r  = 0;
    case (op)
      0:  r = a & b;
      1:  r = a | b;
      2:  r = a ^ b;
      3:  r = 255 - ia;
      4:  r = (ia % 16) * 16 + (ib % 16);
      5:  r = ia / (2 ** (ib % 8));
      6:  r = (ib == 255) ? 1 : 0;
      7:  r = (ia > ib) ? ia : ib;
      8:  r = (ia - ib + 256) % 256;
      9:  r = (ia + ib) % 256;
      10: r = (ia < ib) ? ia : ib;
      default: return 9'h100;
    endcase
    return {1'b0, r[7:0]};
  endfunction

  function automatic logic rdy(input int p);
    return p ? req1_ready : req0_ready;
  endfunction
  function automatic logic rvld(input int p);
    return p ? rsp1_valid : rsp0_valid;
  endfunction
  function automatic logic [7:0] rdata(input int p);
    return p ? rsp1_data : rsp0_data;
  endfunction
  function automatic logic rerr(input int p);
    return p ? rsp1_err : rsp0_err;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (p == 1) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Single transaction on port p with rsp_ready high; operands are scrambled after acceptance.
  task automatic issue(input int p, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    logic [8:0] e;
    int n;
    e = ref_alu(op, a, b);
    set_req(p, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!rdy(p) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", rdy(p), 1);
    @(posedge clk); #1;
    set_req(p, 1'b0, ~op, ~a, ~b);
    check("exec_busy", busy, 1);
    check("exec_rsp_valid", rvld(p), 0);
    @(posedge clk); #1;
    check("rsp_valid", rvld(p), 1);
    check("rsp_other_valid", rvld(1 - p), 0);
    check("rsp_data", rdata(p), e[7:0]);
    check("rsp_err", rerr(p), e[8]);
    @(posedge clk); #1;
    check("rsp_taken", rvld(p), 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    logic [8:0] e;
    int n, g;
    rst_n = 1'b0;
    set_req(0, 1'b0, 4'd0, 8'h00, 8'h00);
    set_req(1, 1'b0, 4'd0, 8'h00, 8'h00);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp0_data", rsp0_data, 0);
    check("rst_rsp1_data", rsp1_data, 0);
    check("rst_rsp0_err", rsp0_err, 0);
    check("rst_rsp1_err", rsp1_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First operation and opcode sweep
    issue(0, 4'd0, 8'hB3, 8'hF0);
    check("sweep_op0_data", rsp0_data, 8'hB0);
    for (int op = 1; op <= 12; op++) begin
      if (op != 11) issue(0, op[3:0], 8'hB3, (op == 5) ? 8'h03 : 8'hF0);
    end
    check("sweep_op12_err", rsp0_err, 1);
    issue(1, 4'd5, 8'hB3, 8'h03);
    check("op5_data", rsp1_data, 8'h16);

    // Random single-requester traffic
    for (int i = 0; i < 30; i++) begin
      issue($urandom_range(0, 1), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end

    // Stalled response on port 1 with port 0 waiting
    set_req(1, 1'b1, 4'd9, 8'h20, 8'h07);
    rsp1_ready = 1'b0;
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_accept1", req1_ready, 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 4'd0, 8'h00, 8'h00);
    set_req(0, 1'b1, 4'd2, 8'h0F, 8'hFF);
    #1;
    check("stall_exec_ready0", req0_ready, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", rsp1_valid, 1);
      check("stall_data", rsp1_data, 8'h27);
      check("stall_busy", busy, 1);
      check("stall_ready0", req0_ready, 0);
      check("stall_ready1", req1_ready, 0);
      check("stall_rsp0_valid", rsp0_valid, 0);
      @(posedge clk); #1;
    end
    rsp1_ready = 1'b1;
    #1;
    check("stall_release_ready0", req0_ready, 0);
    @(posedge clk); #1;
    check("stall_taken", rsp1_valid, 0);
    check("stall_idle_busy", busy, 0);
    check("stall_ready0_after", req0_ready, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'd0, 8'h00, 8'h00);
    check("stall_req0_exec", busy, 1);
    @(posedge clk); #1;
    check("stall_rsp0_valid_after", rsp0_valid, 1);
    check("stall_rsp0_data", rsp0_data, 8'hF0);
    @(posedge clk); #1;

    // Reset during EXEC discards the operation
    set_req(0, 1'b1, 4'd9, 8'h01, 8'h01);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'd0, 8'h00, 8'h00);
    check("mid_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp0_valid", rsp0_valid, 0);
    check("mid_rst_rsp0_data", rsp0_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_rsp0_valid", rsp0_valid, 0);
      check("post_rst_rsp1_valid", rsp1_valid, 0);
      check("post_rst_busy", busy, 0);
    end

    // Both requesters valid continuously: grants alternate starting at 0
    set_req(0, 1'b1, 4'd9, 8'h11, 8'h22);
    set_req(1, 1'b1, 4'd8, 8'h50, 8'h13);
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("tie_one_ready", req0_ready ^ req1_ready, 1);
      g = req1_ready ? 1 : 0;
      check("tie_grant", g, k % 2);
      e = (g == 1) ? ref_alu(4'd8, 8'h50, 8'h13) : ref_alu(4'd9, 8'h11, 8'h22);
      @(posedge clk); #1;
      check("tie_exec_ready", req0_ready | req1_ready, 0);
      @(posedge clk); #1;
      check("tie_rsp_valid", rvld(g), 1);
      check("tie_idle_port_valid", rvld(1 - g), 0);
      check("tie_rsp_data", rdata(g), e[7:0]);
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 4'd0, 8'h00, 8'h00);
    set_req(1, 1'b0, 4'd0, 8'h00, 8'h00);
    @(posedge clk); #1;
    check("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
